// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
//
// Holds NREGS registers of DATA_W bits. NWR write ports commit on the rising
// edge of clk_i, and NRD read ports return data combinationally. With
// BYPASS=1, a read sees same-cycle write data. A per-register busy scoreboard
// tracks writebacks that are still in flight. With ZERO_REG=1, register 0
// always reads as zero, ignores writes and is never busy.
//
// Ports
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset; clears storage and scoreboard
//   wen_i       per-port write enable                  [NWR]
//   waddr_i     write addresses, port k at [k*AW +: AW]
//   wdata_i     write data, port k at [k*DATA_W +: DATA_W]
//   raddr_i     read addresses, port j at [j*AW +: AW]
//   rdata_o     read data, port j at [j*DATA_W +: DATA_W]
//   rbusy_o     read port j addresses a register with a pending write
//   set_busy_i  mark register set_addr_i as pending
//   set_addr_i  register to mark pending
//   busy_o      registered scoreboard vector           [NREGS]
//   dbg_o       stored (non-bypassed) value of register DBG_IDX
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int DBG_IDX  = 10,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NWR-1:0]        wen_i,
  input  logic [NWR*AW-1:0]     waddr_i,
  input  logic [NWR*DATA_W-1:0] wdata_i,
  input  logic [NRD*AW-1:0]     raddr_i,
  output logic [NRD*DATA_W-1:0] rdata_o,
  output logic [NRD-1:0]        rbusy_o,
  input  logic                  set_busy_i,
  input  logic [AW-1:0]         set_addr_i,
  output logic [NREGS-1:0]      busy_o,
  output logic [DATA_W-1:0]     dbg_o
);

  logic [DATA_W-1:0] mem     [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  // Per-register view of this cycle's writes, after port priority and
  // zero-register masking. Storage, bypass and scoreboard all share it, so
  // the three always agree on which port won.
  logic [NREGS-1:0]  wr_hit;
  logic [DATA_W-1:0] wr_data [NREGS];

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    localparam bit IS_ZERO = (ZERO_REG != 0) && (r == 0);

    // Ports are scanned in ascending order, so the highest-index enabled
    // port that matches leaves the final value.
    always_comb begin
      // NOTE: combinational blocks use blocking '=' and assign every output
      // a default first; otherwise a latch is inferred on the untaken path.
      wr_hit[r]  = 1'b0;
      wr_data[r] = '0;
      for (int k = 0; k < NWR; k++) begin
        if (wen_i[k] && (waddr_i[k*AW +: AW] == AW'(r))) begin
          wr_hit[r]  = 1'b1;
          wr_data[r] = wdata_i[k*DATA_W +: DATA_W];
        end
      end
      if (IS_ZERO) begin
        wr_hit[r] = 1'b0;
      end
    end

    // A retiring write clears the busy bit, and a new producer sets it.
    // When both happen in the same cycle, the set wins, because the younger
    // producer is still outstanding.
    assign busy_d[r] = (busy_q[r] & ~wr_hit[r])
                     | (set_busy_i && (set_addr_i == AW'(r)) && !IS_ZERO);

    // NOTE: the storage array is reset explicitly. Reads right after reset
    // must return zero, so every register is a resettable flop and not an
    // uninitialised RAM. Sequential state uses non-blocking '<='.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        mem[r] <= '0;
      end else if (wr_hit[r]) begin
        mem[r] <= wr_data[r];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]     ra;
    logic              zero_hit;
    logic              byp_hit;
    logic [DATA_W-1:0] rd;

    assign ra       = raddr_i[j*AW +: AW];
    assign zero_hit = (ZERO_REG != 0) && (ra == '0);
    assign byp_hit  = (BYPASS != 0) && wr_hit[ra];

    always_comb begin
      rd = mem[ra];
      if (byp_hit) begin
        rd = wr_data[ra];
      end
      if (zero_hit) begin
        rd = '0;
      end
    end

    assign rdata_o[j*DATA_W +: DATA_W] = rd;
    // A write landing this cycle satisfies the pending producer as seen by
    // the reader, so the busy flag is masked whenever the data is bypassed.
    assign rbusy_o[j] = busy_q[ra] & ~byp_hit & ~zero_hit;
  end

  assign busy_o = busy_q;
  assign dbg_o  = mem[DBG_IDX];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp.
// Two instances share the same stimulus: dut_b with BYPASS=1 and dut_n with
// BYPASS=0, both with two read ports and two write ports. Expected values
// come from an array model of the register file and its scoreboard.
module tb_regfile_mp;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int DBG = 10;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [NWR-1:0]    wen_i = '0;
  logic [NWR*AW-1:0] waddr_i = '0;
  logic [NWR*DW-1:0] wdata_i = '0;
  logic [NRD*AW-1:0] raddr_i = '0;
  logic              set_busy_i = 1'b0;
  logic [AW-1:0]     set_addr_i = '0;

  logic [NRD*DW-1:0] rdata_b, rdata_n;
  logic [NRD-1:0]    rbusy_b, rbusy_n;
  logic [NR-1:0]     busy_b, busy_n;
  logic [DW-1:0]     dbg_b, dbg_n;

  regfile_mp #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR),
               .ZERO_REG(1), .BYPASS(1), .DBG_IDX(DBG)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .wen_i(wen_i), .waddr_i(waddr_i),
    .wdata_i(wdata_i), .raddr_i(raddr_i), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
    .set_busy_i(set_busy_i), .set_addr_i(set_addr_i), .busy_o(busy_b), .dbg_o(dbg_b));

  regfile_mp #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR),
               .ZERO_REG(1), .BYPASS(0), .DBG_IDX(DBG)) dut_n (
    .clk_i(clk_i), .rst_ni(rst_ni), .wen_i(wen_i), .waddr_i(waddr_i),
    .wdata_i(wdata_i), .raddr_i(raddr_i), .rdata_o(rdata_n), .rbusy_o(rbusy_n),
    .set_busy_i(set_busy_i), .set_addr_i(set_addr_i), .busy_o(busy_n), .dbg_o(dbg_n));

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural register contents and pending flags.
  logic [DW-1:0] m_reg  [NR];
  bit            m_busy [NR];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_reg[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // A write to addr is visible this cycle if some enabled port targets it.
  // Ports are scanned from highest index downward, so the first match found
  // is the port that takes priority.
  function automatic bit pending_write(input int addr, output logic [DW-1:0] data);
    data = '0;
    if (addr == 0) return 1'b0;
    for (int k = NWR - 1; k >= 0; k--) begin
      if (wen_i[k] && int'(waddr_i[k*AW +: AW]) == addr) begin
        data = wdata_i[k*DW +: DW];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_read(input int addr, input bit byp);
    logic [DW-1:0] d;
    if (addr == 0) return '0;
    if (byp && pending_write(addr, d)) return d;
    return m_reg[addr];
  endfunction

  function automatic logic exp_rbusy(input int addr, input bit byp);
    logic [DW-1:0] d;
    if (addr == 0) return 1'b0;
    if (byp && pending_write(addr, d)) return 1'b0;
    return m_busy[addr];
  endfunction

  function automatic logic [NR-1:0] exp_busy_vec();
    logic [NR-1:0] v;
    for (int r = 0; r < NR; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_commit();
    logic [DW-1:0] d;
    for (int r = 1; r < NR; r++) begin
      if (pending_write(r, d)) begin
        m_reg[r]  = d;
        m_busy[r] = 1'b0;
      end
    end
    if (set_busy_i && set_addr_i != '0) m_busy[int'(set_addr_i)] = 1'b1;
  endtask

  task automatic check_comb(input string tag);
    for (int j = 0; j < NRD; j++) begin
      int a;
      a = int'(raddr_i[j*AW +: AW]);
      check($sformatf("%s rd%0d_byp", tag, j), 64'(rdata_b[j*DW +: DW]), 64'(exp_read(a, 1'b1)));
      check($sformatf("%s rd%0d_nob", tag, j), 64'(rdata_n[j*DW +: DW]), 64'(exp_read(a, 1'b0)));
      check($sformatf("%s rbusy%0d_byp", tag, j), 64'(rbusy_b[j]), 64'(exp_rbusy(a, 1'b1)));
      check($sformatf("%s rbusy%0d_nob", tag, j), 64'(rbusy_n[j]), 64'(exp_rbusy(a, 1'b0)));
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " busy_byp"}, 64'(busy_b), 64'(exp_busy_vec()));
    check({tag, " busy_nob"}, 64'(busy_n), 64'(exp_busy_vec()));
    check({tag, " dbg_byp"}, 64'(dbg_b), 64'(m_reg[DBG]));
    check({tag, " dbg_nob"}, 64'(dbg_n), 64'(m_reg[DBG]));
  endtask

  task automatic idle();
    wen_i      = '0;
    set_busy_i = 1'b0;
  endtask

  // Inputs are applied just after a falling edge. Combinational outputs are
  // checked before the rising edge, and registered state after the next
  // falling edge.
  task automatic step(input string tag);
    #1 check_comb(tag);
    @(posedge clk_i);
    model_commit();
    @(negedge clk_i);
    check_state(tag);
    idle();
  endtask

  task automatic set_wr(input int k, input int addr, input logic [DW-1:0] data);
    wen_i[k]               = 1'b1;
    waddr_i[k*AW +: AW]    = AW'(addr);
    wdata_i[k*DW +: DW]    = data;
  endtask

  task automatic set_rd(input int a0, input int a1);
    raddr_i = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    model_reset();

    // Reset held low: every address reads zero on both ports.
    #2;
    for (int a = 0; a < NR; a++) begin
      set_rd(a, NR - 1 - a);
      #1 check_comb($sformatf("reset a%0d", a));
    end
    check_state("reset");

    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_state("post_reset");

    // x10 = DEADBEEF, read back on both ports the next cycle.
    set_rd(10, 10);
    set_wr(0, 10, 32'hDEADBEEF);
    step("wr_x10");
    check("x10 const rd0", 64'(rdata_b[DW-1:0]), 64'h0000_0000_DEAD_BEEF);
    check("x10 const dbg", 64'(dbg_n), 64'h0000_0000_DEAD_BEEF);
    step("rd_x10");

    // Writes to x0 are discarded, including on the bypass path.
    set_rd(0, 0);
    set_wr(0, 0, 32'h1234);
    step("wr_x0");
    check("x0 const", 64'(rdata_b[DW-1:0]), 64'h0);
    step("rd_x0");

    // Same-cycle write and read of x5: only the bypass instance forwards.
    set_rd(5, 5);
    set_wr(0, 5, 32'hA5A5A5A5);
    #1 check("byp x5 const", 64'(rdata_b[DW-1:0]), 64'h0000_0000_A5A5_A5A5);
    check("nob x5 const", 64'(rdata_n[DW-1:0]), 64'h0);
    step("byp_x5");
    step("rd_x5");

    // Both write ports hit x7; port 1 wins.
    set_rd(7, 7);
    set_wr(0, 7, 32'h11);
    set_wr(1, 7, 32'h22);
    #1 check("conflict x7 const", 64'(rdata_b[DW +: DW]), 64'h22);
    step("conflict_x7");
    step("rd_x7");

    // Scoreboard: set, set-over-clear, then clear.
    set_rd(3, 4);
    set_busy_i = 1'b1;
    set_addr_i = 5'd3;
    step("set_x3");
    check("busy x3 const", 64'(busy_b[3]), 64'h1);
    step("busy_x3");
    set_wr(0, 3, 32'h33);
    set_busy_i = 1'b1;
    set_addr_i = 5'd3;
    step("set_clr_x3");
    set_wr(0, 3, 32'h44);
    #1 check("rbusy x3 byp const", 64'(rbusy_b[0]), 64'h0);
    check("rbusy x3 nob const", 64'(rbusy_n[0]), 64'h1);
    step("clr_x3");
    step("idle_x3");

    // Busy on x0 is ignored.
    set_rd(0, 3);
    set_busy_i = 1'b1;
    set_addr_i = 5'd0;
    step("set_x0");

    // Randomized traffic, biased to low addresses to provoke conflicts.
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < NWR; k++) begin
        if ($urandom_range(0, 2) != 0) set_wr(k, int'($urandom_range(0, 11)), $urandom);
      end
      set_rd(int'($urandom_range(0, 11)), int'($urandom_range(0, 31)));
      set_busy_i = ($urandom_range(0, 2) == 0);
      set_addr_i = AW'($urandom_range(0, 11));
      step($sformatf("rand%0d", n));
    end

    // Asynchronous reset in the middle of a cycle.
    set_rd(10, 4);
    set_wr(0, 10, 32'hCAFE0010);
    set_busy_i = 1'b1;
    set_addr_i = 5'd4;
    step("pre_arst");
    check("pre_arst busy4", 64'(busy_b[4]), 64'h1);
    #2 rst_ni = 1'b0;
    model_reset();
    #1 check_state("arst");
    check_comb("arst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_state("post_arst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
